button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 20 ++
 rtl/button_channel.sv | 124 ++++++++++++
 rtl/button_conditioner.sv | 46 ++++
 tb/tb_button_conditioner.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared constants and repeat-FSM state type for the four-button front panel.
package button_pkg;

  localparam int NUM_BTN       = 4;
  localparam int BTN_WAITING   = 0;
  localparam int BTN_LEFT      = 1;
  localparam int BTN_RIGHT     = 2;
  localparam int BTN_SELECTION = 3;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchronizer, debounce, edge pulses and auto-repeat FSM.
//   state      | meaning
//   RPT_IDLE   | button released, timer held at zero
//   RPT_DELAY  | pressed, waiting REPEAT_DELAY cycles for the first repeat
//   RPT_REPEAT | held past the delay, one repeat every REPEAT_PERIOD cycles
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat,
  output logic press_next
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  logic            sync1, sync2, pressed_s;
  logic [DB_W-1:0] db_cnt, db_cnt_next;
  logic [RT_W-1:0] tmr, tmr_next;
  logic            level_next, rise, fall, rpt_fire;
  rpt_state_t      state, state_next;

  // Raw input is active-low; flops reset to 1 so a reset looks like "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign pressed_s = ~sync2;

  always_comb begin
    db_cnt_next = '0;
    level_next  = btn_level;
    if (pressed_s != btn_level) begin
      if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_next  = pressed_s;
        db_cnt_next = '0;
      end else if (db_cnt != '1) begin
        db_cnt_next = db_cnt + 1'b1;
      end else begin
        db_cnt_next = db_cnt;
      end
    end
  end

  assign rise       = level_next & ~btn_level;
  assign fall       = ~level_next & btn_level;
  assign press_next = rise;

  always_comb begin
    state_next = state;
    tmr_next   = tmr;
    rpt_fire   = 1'b0;
    case (state)
      RPT_IDLE: begin
        tmr_next = '0;
        if (rise) state_next = RPT_DELAY;
      end
      RPT_DELAY: begin
        if (tmr == RT_W'(REPEAT_DELAY - 1)) begin
          rpt_fire   = 1'b1;
          state_next = RPT_REPEAT;
          tmr_next   = '0;
        end else if (tmr != '1) begin
          tmr_next = tmr + 1'b1;
        end
      end
      RPT_REPEAT: begin
        if (tmr == RT_W'(REPEAT_PERIOD - 1)) begin
          rpt_fire = 1'b1;
          tmr_next = '0;
        end else if (tmr != '1) begin
          tmr_next = tmr + 1'b1;
        end
      end
      default: begin
        state_next = RPT_IDLE;
        tmr_next   = '0;
      end
    endcase
    // Release wins over everything, including a repeat due this cycle.
    if (fall) begin
      state_next = RPT_IDLE;
      tmr_next   = '0;
      rpt_fire   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt      <= '0;
      tmr         <= '0;
      state       <= RPT_IDLE;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      db_cnt      <= db_cnt_next;
      tmr         <= tmr_next;
      state       <= state_next;
      btn_level   <= level_next;
      btn_press   <= rise;
      btn_release <= fall;
      btn_repeat  <= rpt_fire & repeat_en;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Four independent button channels plus a registered any-press flag.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   btn_in,
  input  logic [3:0]   repeat_en,
  output logic [3:0]   btn_level,
  output logic [3:0]   btn_press,
  output logic [3:0]   btn_release,
  output logic [3:0]   btn_repeat,
  output logic         any_press
);

  logic [NUM_BTN-1:0] press_next;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_in[i]),
      .repeat_en   (repeat_en[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i]),
      .press_next  (press_next[i])
    );
  end

  // Built from the channels' next-cycle press so it lines up with btn_press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_press <= 1'b0;
    else        any_press <= |press_next;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timings.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_in;
  logic [3:0] repeat_en;
  logic [3:0] btn_level, btn_press, btn_release, btn_repeat;
  logic       any_press;

  int total = 0;
  int bad   = 0;
  int cur_n = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES (8),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .repeat_en   (repeat_en),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat),
    .any_press   (any_press)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, cur_n, obs, exp);
    end
  endtask

  task automatic check_all(input logic [3:0] lvl, input logic [3:0] prs,
                           input logic [3:0] rel, input logic [3:0] rpt,
                           input logic anyp);
    chk("level",   btn_level,   lvl);
    chk("press",   btn_press,   prs);
    chk("release", btn_release, rel);
    chk("repeat",  btn_repeat,  rpt);
    chk("any",     {3'b000, any_press}, {3'b000, anyp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press the channels in mask right after an edge (n=0) and hold for
  // `hold` cycles; repeat_en switches from en0 to en1 after cycle sw.
  task automatic hold_test(input logic [3:0] mask, input int hold,
                           input logic [3:0] en0, input int sw,
                           input logic [3:0] en1, input int len);
    logic [3:0] en_eff;
    logic [3:0] e_lvl, e_prs, e_rel, e_rpt;
    btn_in    = ~mask;
    repeat_en = en0;
    en_eff    = en0;
    for (int n = 1; n <= len; n++) begin
      tick();
      cur_n = n;
      e_lvl = (n >= 10 && n < hold + 10) ? mask : 4'b0000;
      e_prs = (n == 10) ? mask : 4'b0000;
      e_rel = (n == hold + 10) ? mask : 4'b0000;
      e_rpt = (n >= 30 && n < hold + 10 && (n - 30) % 10 == 0) ? (mask & en_eff) : 4'b0000;
      check_all(e_lvl, e_prs, e_rel, e_rpt, n == 10);
      if (n == hold) btn_in = 4'hF;
      if (n == sw) begin
        repeat_en = en1;
        en_eff    = en1;
      end
    end
    repeat_en = 4'b0000;
    for (int n = 0; n < 4; n++) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    btn_in    = 4'hF;
    repeat_en = 4'b0000;

    tick();
    tick();
    cur_n = 0;
    check_all(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    check_all(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Single press on LEFT, no repeat.
    hold_test(4'b0010, 40, 4'b0000, -1, 4'b0000, 55);

    // Short glitches on RIGHT never get through.
    for (int r = 0; r < 3; r++) begin
      btn_in = 4'b1011;
      for (int n = 0; n < 5; n++) begin
        tick();
        cur_n = r * 8 + n;
        check_all(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      end
      btn_in = 4'hF;
      for (int n = 5; n < 8; n++) begin
        tick();
        cur_n = r * 8 + n;
        check_all(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      end
    end
    for (int n = 0; n < 12; n++) begin
      tick();
      check_all(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    end

    // SELECTION with repeat on, off, and enabled mid-hold.
    hold_test(4'b1000, 60, 4'b1000, -1, 4'b1000, 75);
    hold_test(4'b1000, 60, 4'b0000, -1, 4'b0000, 75);
    hold_test(4'b1000, 60, 4'b0000, 35, 4'b1000, 75);

    // WAITING and LEFT together.
    hold_test(4'b0011, 15, 4'b0011, -1, 4'b0011, 30);

    // Reset in the middle of a repeating hold on RIGHT.
    btn_in    = 4'b1011;
    repeat_en = 4'b0100;
    for (int n = 1; n <= 35; n++) begin
      tick();
      cur_n = n;
      check_all((n >= 10) ? 4'b0100 : 4'b0000,
                (n == 10) ? 4'b0100 : 4'b0000,
                4'b0000,
                (n == 30) ? 4'b0100 : 4'b0000,
                n == 10);
    end
    rst_n = 1'b0;
    #1;
    cur_n = 35;
    check_all(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int n = 36; n <= 40; n++) begin
      tick();
      cur_n = n;
      check_all(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    end
    rst_n = 1'b1;
    for (int n = 41; n <= 55; n++) begin
      tick();
      cur_n = n;
      check_all((n >= 50) ? 4'b0100 : 4'b0000,
                (n == 50) ? 4'b0100 : 4'b0000,
                4'b0000, 4'b0000, n == 50);
    end
    btn_in    = 4'hF;
    repeat_en = 4'b0000;
    for (int n = 1; n <= 12; n++) tick();
    cur_n = 12;
    check_all(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
